// File: rtl/sw_arb_pkg.sv
// Shared types and constants for the switch scan sequencer and ownership arbiter.
package sw_arb_pkg;

    localparam int ID_W = 4;

    // ID value meaning "no switch"
    localparam logic [ID_W-1:0] NONE_ID = 4'hF;

    // Event direction encoding carried on EVT_UP
    localparam logic EVT_DOWN = 1'b0;
    localparam logic EVT_UP   = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DWELL  = 3'd1,
        CHECK  = 3'd2,
        REPORT = 3'd3,
        COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/sw_rr_next_owner.sv
// Round-robin owner finder: first raised switch after the current owner,
// searching owner+1 upward and wrapping to owner-1. The owner itself is excluded.
module sw_rr_next_owner #(
    parameter int NUM_SW = 10
) (
    input  logic [NUM_SW-1:0] hist_i,
    input  logic [3:0]        owner_i,
    output logic [3:0]        next_id_o,
    output logic              next_valid_o
);
    import sw_arb_pkg::*;

    logic [3:0] idx;

    // Scan candidates in hand-over order and keep the first hit
    always_comb begin
        next_id_o    = NONE_ID;
        next_valid_o = 1'b0;
        idx          = 4'd0;
        for (int k = 1; k < NUM_SW; k++) begin
            idx = 4'((int'(owner_i) + k) % NUM_SW);
            if (!next_valid_o && hist_i[idx]) begin
                next_valid_o = 1'b1;
                next_id_o    = idx;
            end
        end
    end

endmodule

// File: rtl/sw_scan_arbiter.sv
// Switch scan sequencer and single-resource ownership arbiter.
// Scans one switch per slot, reports each changed switch as a valid/ready
// event, commits it to the history, then updates first-up-wins ownership.
// Optional build macro SW_ARB_TIMEOUT_EN: an event left unaccepted for
// EVT_TIMEOUT cycles is dropped (sticky DROP_FLAG) and re-detected next pass.
// Handshake: an event is transferred on a rising CLK edge where EVT_VALID and
// EVT_READY are both 1; EVT_ID/EVT_UP stay stable while EVT_VALID is 1.
module sw_scan_arbiter #(
    parameter int NUM_SW      = 10,
    parameter int SCAN_DIV    = 4,
    parameter int EVT_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_SW-1:0] SW,
    input  logic              SCAN_EN,
    input  logic              EVT_READY,
    output logic              EVT_VALID,
    output logic [3:0]        EVT_ID,
    output logic              EVT_UP,
    output logic [3:0]        SCAN_COUNTER,
    output logic [NUM_SW-1:0] SW_HISTORY,
    output logic              OWNER_VALID,
    output logic [3:0]        OWNER_ID,
    output logic [3:0]        PENDING_CNT,
    output logic              DROP_FLAG
);
    import sw_arb_pkg::*;

    localparam int DW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

    state_t            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [3:0]        scan_q, scan_d;
    logic [NUM_SW-1:0] hist_q, hist_d;
    logic              evt_valid_q, evt_valid_d;
    logic [3:0]        evt_id_q, evt_id_d;
    logic              evt_up_q, evt_up_d;
    logic              owner_valid_q, owner_valid_d;
    logic [3:0]        owner_id_q, owner_id_d;
    logic [3:0]        pending_q, pending_d;
    logic              drop_q, drop_d;

    logic              sw_bit;
    logic              dwell_done;
    logic [3:0]        scan_inc;
    logic              timeout_hit;
    logic [NUM_SW-1:0] hist_commit;
    logic [4:0]        hist_pop;
    logic [4:0]        pend_raw;
    logic [3:0]        rr_id;
    logic              rr_valid;

    assign sw_bit     = SW[scan_q];
    assign dwell_done = (dwell_q == DW'(SCAN_DIV - 1));
    assign scan_inc   = (scan_q == 4'(NUM_SW - 1)) ? 4'd0 : scan_q + 4'd1;

`ifdef SW_ARB_TIMEOUT_EN
    localparam int TW = $clog2(EVT_TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;

    // Count cycles spent waiting in REPORT; cleared everywhere else
    always_comb begin
        to_d = '0;
        if (state_q == REPORT && !EVT_READY) to_d = to_q + 1'b1;
    end

    // Wait counter register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) to_q <= '0;
        else       to_q <= to_d;
    end

    assign timeout_hit = (state_q == REPORT) && !EVT_READY && (to_q == TW'(EVT_TIMEOUT - 1));
`else
    // REPORT never times out in this build; EVT_TIMEOUT is never negative
    assign timeout_hit = (EVT_TIMEOUT < 0);
`endif

    // History as it will look after committing the pending event
    always_comb begin
        hist_commit           = hist_q;
        hist_commit[evt_id_q] = evt_up_q;
    end

    // Number of raised switches in the post-commit history
    always_comb begin
        hist_pop = 5'd0;
        for (int i = 0; i < NUM_SW; i++) hist_pop = hist_pop + {4'd0, hist_commit[i]};
    end

    sw_rr_next_owner #(.NUM_SW(NUM_SW)) u_rr (
        .hist_i       (hist_commit),
        .owner_i      (owner_id_q),
        .next_id_o    (rr_id),
        .next_valid_o (rr_valid)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; SCAN_EN is only honoured at slot end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (SCAN_EN) state_d = DWELL;
            DWELL:   if (dwell_done) state_d = CHECK;
            CHECK:   begin
                if (sw_bit != hist_q[scan_q]) state_d = REPORT;
                else                          state_d = SCAN_EN ? DWELL : IDLE;
            end
            REPORT:  begin
                if (EVT_READY)        state_d = COMMIT;
                else if (timeout_hit) state_d = SCAN_EN ? DWELL : IDLE;
            end
            COMMIT:  state_d = SCAN_EN ? DWELL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: next values of the datapath registers
    always_comb begin
        dwell_d       = '0;
        scan_d        = scan_q;
        hist_d        = hist_q;
        evt_valid_d   = evt_valid_q;
        evt_id_d      = evt_id_q;
        evt_up_d      = evt_up_q;
        owner_valid_d = owner_valid_q;
        owner_id_d    = owner_id_q;
        pending_d     = pending_q;
        drop_d        = drop_q;
        pend_raw      = 5'd0;
        case (state_q)
            DWELL: dwell_d = dwell_done ? '0 : dwell_q + 1'b1;
            CHECK: begin
                if (sw_bit != hist_q[scan_q]) begin
                    evt_valid_d = 1'b1;
                    evt_id_d    = scan_q;
                    evt_up_d    = sw_bit;
                end else begin
                    scan_d = scan_inc;
                end
            end
            REPORT: begin
                if (EVT_READY) begin
                    evt_valid_d = 1'b0;
                end else if (timeout_hit) begin
                    evt_valid_d = 1'b0;
                    drop_d      = 1'b1;
                    scan_d      = scan_inc;
                end
            end
            COMMIT: begin
                hist_d = hist_commit;
                scan_d = scan_inc;
                if (evt_up_q == sw_arb_pkg::EVT_UP) begin
                    if (!owner_valid_q) begin
                        owner_valid_d = 1'b1;
                        owner_id_d    = evt_id_q;
                    end
                end else if (owner_valid_q && owner_id_q == evt_id_q) begin
                    owner_valid_d = rr_valid;
                    owner_id_d    = rr_valid ? rr_id : NONE_ID;
                end
                pend_raw  = hist_pop - {4'd0, owner_valid_d};
                pending_d = (pend_raw > 5'd15) ? 4'd15 : pend_raw[3:0];
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dwell_q       <= '0;
            scan_q        <= 4'd0;
            hist_q        <= '0;
            evt_valid_q   <= 1'b0;
            evt_id_q      <= NONE_ID;
            evt_up_q      <= 1'b0;
            owner_valid_q <= 1'b0;
            owner_id_q    <= NONE_ID;
            pending_q     <= 4'd0;
            drop_q        <= 1'b0;
        end else begin
            dwell_q       <= dwell_d;
            scan_q        <= scan_d;
            hist_q        <= hist_d;
            evt_valid_q   <= evt_valid_d;
            evt_id_q      <= evt_id_d;
            evt_up_q      <= evt_up_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            pending_q     <= pending_d;
            drop_q        <= drop_d;
        end
    end

    assign EVT_VALID    = evt_valid_q;
    assign EVT_ID       = evt_id_q;
    assign EVT_UP       = evt_up_q;
    assign SCAN_COUNTER = scan_q;
    assign SW_HISTORY   = hist_q;
    assign OWNER_VALID  = owner_valid_q;
    assign OWNER_ID     = owner_id_q;
    assign PENDING_CNT  = pending_q;
    assign DROP_FLAG    = drop_q;

endmodule

// File: tb/tb_sw_scan_arbiter.sv
// Directed bench for sw_scan_arbiter (NUM_SW=10, SCAN_DIV=2, EVT_TIMEOUT=8).
module tb_sw_scan_arbiter;

    logic       CLK;
    logic       RESET;
    logic [9:0] SW;
    logic       SCAN_EN;
    logic       EVT_READY;
    logic       EVT_VALID;
    logic [3:0] EVT_ID;
    logic       EVT_UP;
    logic [3:0] SCAN_COUNTER;
    logic [9:0] SW_HISTORY;
    logic       OWNER_VALID;
    logic [3:0] OWNER_ID;
    logic [3:0] PENDING_CNT;
    logic       DROP_FLAG;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef SW_ARB_TIMEOUT_EN
    localparam int HOLD = 6;
`else
    localparam int HOLD = 20;
`endif

    sw_scan_arbiter #(.NUM_SW(10), .SCAN_DIV(2), .EVT_TIMEOUT(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SW           (SW),
        .SCAN_EN      (SCAN_EN),
        .EVT_READY    (EVT_READY),
        .EVT_VALID    (EVT_VALID),
        .EVT_ID       (EVT_ID),
        .EVT_UP       (EVT_UP),
        .SCAN_COUNTER (SCAN_COUNTER),
        .SW_HISTORY   (SW_HISTORY),
        .OWNER_VALID  (OWNER_VALID),
        .OWNER_ID     (OWNER_ID),
        .PENDING_CNT  (PENDING_CNT),
        .DROP_FLAG    (DROP_FLAG)
    );

    // Clock and cycle count
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [9:0] hist, input logic ov,
                                 input logic [3:0] oid, input logic [3:0] pend, input logic [3:0] scan);
        check({tag, "_hist"},  SW_HISTORY,   hist);
        check({tag, "_ovld"},  OWNER_VALID,  ov);
        check({tag, "_oid"},   OWNER_ID,     oid);
        check({tag, "_pend"},  PENDING_CNT,  pend);
        check({tag, "_scan"},  SCAN_COUNTER, scan);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_evalid"}, EVT_VALID,    1'b0);
        check({tag, "_eid"},    EVT_ID,       4'hF);
        check({tag, "_eup"},    EVT_UP,       1'b0);
        check({tag, "_dropf"},  DROP_FLAG,    1'b0);
        check_outputs(tag, 10'h000, 1'b0, 4'hF, 4'd0, 4'd0);
    endtask

    // Wait (bounded) for EVT_VALID, sampled on falling edges
    task automatic wait_evt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (EVT_VALID) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expect one event with EVT_READY high; returns after the commit cycle
    task automatic do_evt(input string tag, input logic [3:0] id, input logic up);
        bit ok;
        wait_evt(ok);
        check({tag, "_seen"}, ok, 1'b1);
        check({tag, "_id"},   EVT_ID, id);
        check({tag, "_up"},   EVT_UP, up);
        @(negedge CLK);
        check({tag, "_vdrop"}, EVT_VALID, 1'b0);
        @(negedge CLK);
    endtask

    initial begin
        bit   ok;
        bit   seen_valid;
        int   wraps[$];
        logic [3:0] prev;
        int   n;

        RESET = 1'b1; SW = '0; SCAN_EN = 1'b0; EVT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("rst");
        RESET = 1'b0;

        // Scanning disabled: counter holds
        repeat (5) @(negedge CLK);
        check("idle_hold", SCAN_COUNTER, 4'd0);

        // Quiet scan: no events, 30-cycle wrap period
        SCAN_EN = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev = SCAN_COUNTER;
            @(negedge CLK);
            if (EVT_VALID) seen_valid = 1'b1;
            if (prev == 4'd9 && SCAN_COUNTER == 4'd0) wraps.push_back(cyc);
        end
        check("quiet_no_evt", seen_valid, 1'b0);
        check("quiet_wraps", (wraps.size() >= 2), 1'b1);
        if (wraps.size() >= 2) check("wrap_period", 16'(wraps[1] - wraps[0]), 16'd30);

        // First up event takes ownership
        EVT_READY = 1'b1;
        SW[3] = 1'b1;
        do_evt("up3", 4'd3, 1'b1);
        check_outputs("up3", 10'h008, 1'b1, 4'd3, 4'd0, 4'd4);

        // Further up events leave the owner alone
        SW[7] = 1'b1;
        do_evt("up7", 4'd7, 1'b1);
        check_outputs("up7", 10'h088, 1'b1, 4'd3, 4'd1, 4'd8);
        SW[1] = 1'b1;
        do_evt("up1", 4'd1, 1'b1);
        check_outputs("up1", 10'h08A, 1'b1, 4'd3, 4'd2, 4'd2);

        // Owner drops: hand-over searches 4,5,6,7 -> 7
        SW[3] = 1'b0;
        do_evt("dn3", 4'd3, 1'b0);
        check_outputs("dn3", 10'h082, 1'b1, 4'd7, 4'd1, 4'd4);

        // Back-pressure: event held stable, scan frozen
        EVT_READY = 1'b0;
        SW[5] = 1'b1;
        wait_evt(ok);
        check("bp_seen", ok, 1'b1);
        for (int i = 0; i < HOLD; i++) begin
            check("bp_hold", {EVT_VALID, EVT_UP, EVT_ID, SCAN_COUNTER}, {1'b1, 1'b1, 4'd5, 4'd5});
            @(negedge CLK);
        end
        EVT_READY = 1'b1;
        @(negedge CLK);
        check("bp_vdrop", EVT_VALID, 1'b0);
        check("bp_nocommit", SW_HISTORY, 10'h082);
        @(negedge CLK);
        check_outputs("bp", 10'h0A2, 1'b1, 4'd7, 4'd2, 4'd6);

        // Reset while an event is pending
        EVT_READY = 1'b0;
        SW[9] = 1'b1;
        wait_evt(ok);
        check("rr_seen", ok, 1'b1);
        check("rr_id", EVT_ID, 4'd9);
        RESET = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge CLK);
        RESET = 1'b0;
        EVT_READY = 1'b1;

        // First pass after reset re-reports everything still up
        do_evt("re1", 4'd1, 1'b1);
        check_outputs("re1", 10'h002, 1'b1, 4'd1, 4'd0, 4'd2);
        do_evt("re5", 4'd5, 1'b1);
        do_evt("re7", 4'd7, 1'b1);
        do_evt("re9", 4'd9, 1'b1);
        check_outputs("re9", 10'h2A2, 1'b1, 4'd1, 4'd3, 4'd0);

`ifdef SW_ARB_TIMEOUT_EN
        // Unaccepted event times out, is dropped, and comes back next pass
        EVT_READY = 1'b0;
        SW[2] = 1'b1;
        wait_evt(ok);
        check("to_seen", ok, 1'b1);
        check("to_id", EVT_ID, 4'd2);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!EVT_VALID) break;
            n++;
        end
        check("to_len", 16'(n), 16'd8);
        check("to_dropf", DROP_FLAG, 1'b1);
        check_outputs("to", 10'h2A2, 1'b1, 4'd1, 4'd3, 4'd3);
        EVT_READY = 1'b1;
        do_evt("to_re2", 4'd2, 1'b1);
        check_outputs("to_re2", 10'h2A6, 1'b1, 4'd1, 4'd4, 4'd3);
        check("to_sticky", DROP_FLAG, 1'b1);
`else
        check("no_drop", DROP_FLAG, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
